// File: rtl/aq_gmii_rx_frame.sv
// Purpose : GMII receive framer. Strips preamble/SFD, counts length, checks FCS (CRC-32) and
//           delivers frame bytes as a valid/sof/eof stream with a status word on the eof beat.
// Latency : D[k] leaves on rxf_data the cycle after D[k+L] is sampled (L=5 with FCS strip, else 1).
// Backpressure: none; the consumer must take a byte on every rxf_valid cycle.
//
// Ports:
//   rx_clk, rst                        receive clock, synchronous active-high reset
//   bgmii_rxd/bgmii_rxe/bgmii_rxer     registered GMII receive data / data valid / error
//   rxf_data/rxf_valid                 frame byte and its qualifier
//   rxf_sof/rxf_eof                    first / last delivered byte of a frame (qualified by valid)
//   rxf_stat                           {rxer_seen, crc_bad, too_short, too_long}, eof beat only
//
// Build option: define AQ_GMII_RX_FCS_STRIP_EN to drop the four FCS bytes from the stream.
// Length and CRC checks always cover DA through FCS.

module aq_gmii_rx_frame #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input  logic       rx_clk,
   input  logic       rst,
   input  logic [7:0] bgmii_rxd,
   input  logic       bgmii_rxe,
   input  logic       bgmii_rxer,
   output logic [7:0] rxf_data,
   output logic       rxf_valid,
   output logic       rxf_sof,
   output logic       rxf_eof,
   output logic [3:0] rxf_stat
);

`ifdef AQ_GMII_RX_FCS_STRIP_EN
   // Four bytes of look-ahead hide the FCS, plus one to know the current byte is not the last.
   localparam int L = 5;
`else
   // One byte of look-ahead is the minimum needed to flag eof on the final byte.
   localparam int L = 1;
`endif

   localparam logic [10:0] L_W         = 11'(L);
   localparam logic [10:0] MIN_W       = 11'(MIN_LEN);
   localparam logic [10:0] MAX_W       = 11'(MAX_LEN);
   localparam logic [10:0] LEN_SAT     = 11'h7FF;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
   // Register value left after a good frame's data and FCS have been shifted through.
   localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
   localparam logic [7:0]  PRE_BYTE    = 8'h55;
   localparam logic [7:0]  SFD_BYTE    = 8'hD5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      DATA = 2'd2,
      DROP = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  dl_q [L];
   logic [7:0]  dl_d [L];
   logic [10:0] len_q, len_d;
   logic [31:0] crc_q, crc_d;
   logic        rxer_seen_q, rxer_seen_d;
   logic        sof_pend_q, sof_pend_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        sof_q, sof_d;
   logic        eof_q, eof_d;
   logic [3:0]  stat_q, stat_d;
   logic        start_frame;
   logic        flush;

   // MSB-first CRC-32 register fed with each byte LSB first (the Ethernet bit order); this
   // keeps the register bit-reversed relative to the usual reflected software form.
   function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[31] ^ d[i]) begin
            c = {c[30:0], 1'b0} ^ CRC_POLY;
         end else begin
            c = {c[30:0], 1'b0};
         end
      end
      return c;
   endfunction

   always_ff @(posedge rx_clk) begin
      if (rst) begin
         state_q     <= IDLE;
         for (int i = 0; i < L; i++) begin
            dl_q[i] <= 8'h00;
         end
         len_q       <= 11'd0;
         crc_q       <= CRC_INIT;
         rxer_seen_q <= 1'b0;
         sof_pend_q  <= 1'b0;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         sof_q       <= 1'b0;
         eof_q       <= 1'b0;
         stat_q      <= 4'h0;
      end else begin
         state_q     <= state_d;
         for (int i = 0; i < L; i++) begin
            dl_q[i] <= dl_d[i];
         end
         len_q       <= len_d;
         crc_q       <= crc_d;
         rxer_seen_q <= rxer_seen_d;
         sof_pend_q  <= sof_pend_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         sof_q       <= sof_d;
         eof_q       <= eof_d;
         stat_q      <= stat_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      dl_d        = dl_q;
      len_d       = len_q;
      crc_d       = crc_q;
      rxer_seen_d = rxer_seen_q;
      sof_pend_d  = sof_pend_q;
      data_d      = 8'h00;
      valid_d     = 1'b0;
      sof_d       = 1'b0;
      eof_d       = 1'b0;
      stat_d      = 4'h0;
      start_frame = 1'b0;
      flush       = 1'b0;

      case (state_q)
         IDLE: begin
            if (bgmii_rxe) begin
               if (bgmii_rxd == PRE_BYTE) begin
                  state_d = PRE;
               end else if (bgmii_rxd == SFD_BYTE) begin
                  // Preamble may be shortened to nothing by upstream repeaters.
                  state_d     = DATA;
                  start_frame = 1'b1;
               end else begin
                  state_d = DROP;
               end
            end
         end

         PRE: begin
            if (!bgmii_rxe) begin
               state_d = IDLE;
            end else if (bgmii_rxd == SFD_BYTE) begin
               state_d     = DATA;
               start_frame = 1'b1;
            end else if (bgmii_rxd != PRE_BYTE) begin
               state_d = DROP;
            end
         end

         DATA: begin
            if (!bgmii_rxe) begin
               // End of frame: the oldest delay-line byte is the last one to deliver. With
               // len <= L nothing was ever emitted, so the frame vanishes silently.
               state_d = IDLE;
               flush   = 1'b1;
               if (len_q > L_W) begin
                  valid_d = 1'b1;
                  data_d  = dl_q[L-1];
                  sof_d   = sof_pend_q;
                  eof_d   = 1'b1;
                  stat_d  = {rxer_seen_q, (crc_q != CRC_RESIDUE), (len_q < MIN_W), 1'b0};
               end
            end else begin
               if (len_q >= L_W) begin
                  valid_d    = 1'b1;
                  data_d     = dl_q[L-1];
                  sof_d      = sof_pend_q;
                  sof_pend_d = 1'b0;
               end
               if (len_q == MAX_W) begin
                  // Byte MAX_LEN+1 arrived: close the frame on this beat and discard the rest.
                  state_d = DROP;
                  flush   = 1'b1;
                  eof_d   = valid_d;
                  stat_d  = valid_d ? {(rxer_seen_q | bgmii_rxer), 3'b001} : 4'h0;
               end else begin
                  dl_d[0] = bgmii_rxd;
                  for (int i = 1; i < L; i++) begin
                     dl_d[i] = dl_q[i-1];
                  end
                  crc_d       = crc_step(crc_q, bgmii_rxd);
                  len_d       = (len_q == LEN_SAT) ? len_q : len_q + 11'd1;
                  rxer_seen_d = rxer_seen_q | bgmii_rxer;
               end
            end
         end

         DROP: begin
            if (!bgmii_rxe) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (start_frame) begin
         len_d       = 11'd0;
         crc_d       = CRC_INIT;
         rxer_seen_d = 1'b0;
         sof_pend_d  = 1'b1;
      end

      if (flush) begin
         for (int i = 0; i < L; i++) begin
            dl_d[i] = 8'h00;
         end
         len_d       = 11'd0;
         crc_d       = CRC_INIT;
         rxer_seen_d = 1'b0;
         sof_pend_d  = 1'b0;
      end
   end

   assign rxf_data  = data_q;
   assign rxf_valid = valid_q;
   assign rxf_sof   = sof_q;
   assign rxf_eof   = eof_q;
   assign rxf_stat  = stat_q;

endmodule

// File: doc/aq_gmii_rx_frame.md
# aq_gmii_rx_frame

GMII receive framer, directly downstream of the GMII I/O buffer's registered receive outputs (`bgmii_rxd`/`bgmii_rxe`/`bgmii_rxer`), in the `rx_clk` domain.
- Strips preamble and SFD, counts frame length and checks FCS (CRC-32).
- Delivers payload bytes as a valid/sof/eof stream, with a per-frame status word on the eof beat.
- Feeds the MAC receive FIFO; no backpressure exists, so the consumer must accept a byte on every `rxf_valid` cycle.

## Interface
Parameters:
- MIN_LEN, 64: minimum legal frame length in bytes, DA through FCS inclusive.
- MAX_LEN, 1518: maximum legal frame length in bytes, DA through FCS inclusive; 11-bit counter, saturating at 2047.

Ports:
- rx_clk  in  1  receive clock (125 MHz GMII / 2.5–25 MHz MII).
- rst  in  1  reset, synchronous to rx_clk, active-high.
- bgmii_rxd  in  8  registered GMII receive data.
- bgmii_rxe  in  1  registered GMII receive data valid.
- bgmii_rxer  in  1  registered GMII receive error.
- rxf_data  out  8  frame byte.
- rxf_valid  out  1  rxf_data valid this cycle.
- rxf_sof  out  1  first byte of frame (DA[0]); qualified by rxf_valid.
- rxf_eof  out  1  last byte of frame; qualified by rxf_valid.
- rxf_stat  out  4  {rxer_seen, crc_bad, too_short, too_long}; meaningful only on the eof beat, 0 otherwise.

## Operation
- All inputs are sampled every rx_clk edge.
- Frame bytes are counted from the first byte after SFD: D[0] … D[n-1], n includes the 4 FCS bytes.
- Internal delay line of depth L:
  - L = 5 with FCS strip.
  - L = 1 without FCS strip.
- State machine states: IDLE, PRE, DATA, DROP.
  - IDLE:
    - rxe=1, rxd=0x55 → PRE.
    - rxe=1, rxd=0xD5 → DATA (short preamble accepted).
    - rxe=1, any other rxd → DROP.
  - PRE:
    - rxe=0 → IDLE.
    - rxd=0x55 → stay in PRE.
    - rxd=0xD5 → DATA.
    - any other rxd → DROP.
  - DATA:
    - Each sampled byte is shifted into the delay line, the CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, reflected) and the length counter.
    - rxer=1 sets rxer_seen.
    - rxe=0 → IDLE, with frame termination (below).
    - Length reaching MAX_LEN+1 → DROP, with overlength termination (below).
  - DROP: no output; wait for rxe=0 → IDLE.
- Normal termination (rxe sampled 0 in DATA):
  - The byte emitted that cycle, D[n-L], carries eof=1.
  - CRC check: crc_bad = (register ≠ residue 0xC704DD7B).
  - too_short = (n < MIN_LEN).
  - Remaining delay-line contents (FCS, when stripped) are discarded.
- Frames with n ≤ L: no byte was ever emitted, so nothing is output (silent drop); return to IDLE.
- Overlength termination (byte MAX_LEN+1 sampled):
  - The next output beat carries eof=1, too_long=1 and crc_bad=0.
  - The delay line is flushed and the state goes to DROP.
- rxf_sof is asserted on the first emitted byte of every frame.

## Timing
- Reset: every output is 0 on the cycle after rst is sampled high.
  - rxf_data = 0x00, rxf_valid/sof/eof = 0, rxf_stat = 0.
  - State = IDLE; delay line, CRC and counter are cleared.
- Reset mid-frame: the frame is abandoned with no eof emitted.
  - After reset release, if rxe is still high the block enters DROP (or PRE, if rxd happens to be 0x55) and the remainder of that frame is never delivered.
- Latency: D[k] appears on rxf_data in the cycle after D[k+L] is sampled.
  - The last delivered byte appears in the cycle after rxe is sampled 0.
- rxf_valid is contiguous within a frame: no gaps while rxe is held high.
- Back-to-back frames separated by a single rxe=0 cycle:
  - The eof of frame A and the IDLE decode of frame B's first preamble byte occur in the same cycle.
  - No byte of B is lost.

## Configuration
- Macro: `AQ_GMII_RX_FCS_STRIP_EN`.
- Defined:
  - L = 5; the FCS bytes are not delivered.
  - Length checks still include FCS.
- Undefined:
  - L = 1; the FCS bytes are delivered, and the eof beat is FCS[3].
  - CRC check and rxf_stat behaviour are unchanged.

## Test plan
- 7×0x55, 0xD5, 60-byte payload plus correct FCS (n=64), strip on:
  - 60 contiguous valid beats; sof on the first (= DA[0]); eof on byte 59; rxf_stat=0000.
- Same frame with one payload byte flipped:
  - eof beat has rxf_stat=0100; byte count unchanged.
- bgmii_rxer=1 for one cycle mid-frame:
  - rxf_stat bit3=1 on eof; the stream continues to eof.
- 1600-byte frame, MAX_LEN=1518:
  - eof with rxf_stat=0001 on the beat following sampling of byte 1519.
  - No further valid beats until the next frame's SFD.
- 40-byte frame with good CRC → eof with rxf_stat=0010.
  - 4-byte frame with strip on → no rxf_valid at all.
- rst pulsed for 1 cycle at byte 30 of a frame:
  - Outputs all zero the next cycle; no eof for that frame.
  - The following frame is received correctly with rxf_stat=0000.
